// File: rtl/instruction_queue.sv
// instruction_queue: circular FIFO of {pc, inst} between fetch and rename.
// Head entry is presented show-ahead (zero read latency); a branch redirect
// (flush) discards every entry. Pointers carry one extra wrap bit so that
// full and empty can be told apart when the indices match.
// Optional build macro IQUEUE_PERF_EN adds saturating counters for dropped
// enqueues (full_stall_cycles) and flush cycles (flush_count).
module instruction_queue #(
  parameter int DEPTH    = 16,
  parameter int PTR_BITS = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enqueue,
  input  logic [31:0]         inst_in,
  input  logic [31:0]         pc_in,
  input  logic                dequeue,
  input  logic                flush,
  output logic [31:0]         inst,
  output logic [31:0]         prog,
  output logic                is_iqueue_empty,
  output logic                full,
`ifdef IQUEUE_PERF_EN
  output logic [31:0]         full_stall_cycles,
  output logic [31:0]         flush_count,
`endif
  output logic [PTR_BITS:0]   count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } iq_entry_t;

  iq_entry_t               mem [DEPTH];
  logic      [PTR_BITS:0]  head, tail;
  logic                    enq_ok, deq_ok;
  iq_entry_t               head_entry;

  // Occupancy flags come only from the registered pointers.
  assign is_iqueue_empty = (head == tail);
  assign full            = (head[PTR_BITS-1:0] == tail[PTR_BITS-1:0]) &&
                           (head[PTR_BITS] != tail[PTR_BITS]);
  assign count           = tail - head;

  // A pop at full frees the slot the new word lands in, so enqueue at full
  // is still accepted when paired with a dequeue.
  assign deq_ok = dequeue && !is_iqueue_empty;
  assign enq_ok = enqueue && (!full || deq_ok);

  // Show-ahead read; forced to zero while empty so stale storage never leaks.
  assign head_entry = mem[head[PTR_BITS-1:0]];
  assign inst       = is_iqueue_empty ? 32'h0 : head_entry.inst;
  assign prog       = is_iqueue_empty ? 32'h0 : head_entry.pc;

  // Storage write; the array itself is never reset, pointers define validity.
  always_ff @(posedge clk) begin
    if (enq_ok && !flush)
      mem[tail[PTR_BITS-1:0]] <= '{pc: pc_in, inst: inst_in};
  end

  // Pointer update; flush wins over any enqueue/dequeue in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head + {{PTR_BITS{1'b0}}, deq_ok};
      tail <= tail + {{PTR_BITS{1'b0}}, enq_ok};
    end
  end

`ifdef IQUEUE_PERF_EN
  logic enq_drop;

  // A drop is an enqueue refused because the queue was full with no pop.
  assign enq_drop = enqueue && !enq_ok;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_stall_cycles <= '0;
      flush_count       <= '0;
    end else begin
      if (enq_drop && (full_stall_cycles != 32'hFFFF_FFFF))
        full_stall_cycles <= full_stall_cycles + 32'd1;
      if (flush && (flush_count != 32'hFFFF_FFFF))
        flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_queue.sv
// Directed self-checking bench for instruction_queue (DEPTH=16).
module tb_instruction_queue;

  localparam int DEPTH    = 16;
  localparam int PTR_BITS = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                enqueue = 1'b0;
  logic [31:0]         inst_in = '0;
  logic [31:0]         pc_in = '0;
  logic                dequeue = 1'b0;
  logic                flush = 1'b0;
  logic [31:0]         inst, prog;
  logic                is_iqueue_empty, full;
  logic [PTR_BITS:0]   count;
`ifdef IQUEUE_PERF_EN
  logic [31:0]         full_stall_cycles, flush_count;
`endif

  int errors = 0;
  int checks = 0;

  instruction_queue #(.DEPTH(DEPTH), .PTR_BITS(PTR_BITS)) dut (
    .clk(clk), .rst(rst),
    .enqueue(enqueue), .inst_in(inst_in), .pc_in(pc_in),
    .dequeue(dequeue), .flush(flush),
    .inst(inst), .prog(prog),
    .is_iqueue_empty(is_iqueue_empty), .full(full),
`ifdef IQUEUE_PERF_EN
    .full_stall_cycles(full_stall_cycles), .flush_count(flush_count),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic e, input logic d, input logic f,
                      input logic [31:0] i, input logic [31:0] p);
    enqueue = e; dequeue = d; flush = f; inst_in = i; pc_in = p;
    @(posedge clk); #1;
    enqueue = 1'b0; dequeue = 1'b0; flush = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_empty", 32'(is_iqueue_empty), 32'd1);
    chk("rst_full",  32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_inst",  inst, 32'h0);
    chk("rst_prog",  prog, 32'h0);
`ifdef IQUEUE_PERF_EN
    chk("rst_stall", full_stall_cycles, 32'd0);
    chk("rst_flcnt", flush_count, 32'd0);
`endif
    rst = 1'b1;
    @(posedge clk); #1;

    // Three enqueues, visible one cycle later
    step(1, 0, 0, 32'h00000013, 32'h60000000);
    chk("e1_inst",  inst, 32'h00000013);
    chk("e1_prog",  prog, 32'h60000000);
    chk("e1_count", 32'(count), 32'd1);
    chk("e1_empty", 32'(is_iqueue_empty), 32'd0);
    step(1, 0, 0, 32'h00500093, 32'h60000004);
    step(1, 0, 0, 32'h00108133, 32'h60000008);
    chk("e3_count", 32'(count), 32'd3);

    // Pop in order
    chk("d1_inst", inst, 32'h00000013);
    step(0, 1, 0, '0, '0);
    chk("d2_inst", inst, 32'h00500093);
    chk("d2_prog", prog, 32'h60000004);
    step(0, 1, 0, '0, '0);
    chk("d3_inst", inst, 32'h00108133);
    chk("d3_prog", prog, 32'h60000008);
    step(0, 1, 0, '0, '0);
    chk("d_empty", 32'(is_iqueue_empty), 32'd1);
    chk("d_count", 32'(count), 32'd0);

    // Fill to DEPTH
    for (int k = 0; k < DEPTH; k++)
      step(1, 0, 0, 32'(k), 32'h1000 + 32'(4 * k));
    chk("fill_full",  32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_head",  prog, 32'h1000);

    // Dropped 17th enqueue
    step(1, 0, 0, 32'hDEAD, 32'hDEAD);
    chk("drop_count", 32'(count), 32'd16);
    chk("drop_head",  prog, 32'h1000);
`ifdef IQUEUE_PERF_EN
    chk("drop_stall", full_stall_cycles, 32'd1);
`endif

    // Hold full with push+pop for 40 cycles: 2.5 wraps of the head
    for (int k = 0; k < 40; k++) begin
      chk("hold_pc", prog, 32'h1000 + 32'(4 * k));
      step(1, 1, 0, 32'(k + 16), 32'h1000 + 32'(4 * (k + 16)));
      chk("hold_count", 32'(count), 32'd16);
    end
    chk("hold_full", 32'(full), 32'd1);
    chk("hold_inst", inst, 32'd40);
`ifdef IQUEUE_PERF_EN
    chk("hold_stall", full_stall_cycles, 32'd1);
`endif

    // Drain to 5 entries
    for (int k = 0; k < 11; k++) begin
      chk("drain_pc", prog, 32'h1000 + 32'(4 * (40 + k)));
      step(0, 1, 0, '0, '0);
    end
    chk("drain_count", 32'(count), 32'd5);

    // Flush beats simultaneous enqueue/dequeue
    step(1, 1, 1, 32'hBAD0, 32'hBAD0);
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_empty", 32'(is_iqueue_empty), 32'd1);
    chk("fl_inst",  inst, 32'h0);
    chk("fl_prog",  prog, 32'h0);
`ifdef IQUEUE_PERF_EN
    chk("fl_flcnt", flush_count, 32'd1);
`endif
    step(1, 0, 0, 32'h0000AABB, 32'h2000);
    chk("pfl_inst",  inst, 32'h0000AABB);
    chk("pfl_prog",  prog, 32'h2000);
    chk("pfl_count", 32'(count), 32'd1);
    step(0, 1, 0, '0, '0);

    // Dequeue while empty: no underflow
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, '0, '0);
      chk("uf_count", 32'(count), 32'd0);
      chk("uf_empty", 32'(is_iqueue_empty), 32'd1);
    end
    step(1, 0, 0, 32'h77, 32'h3000);
    chk("uf_inst", inst, 32'h77);
    chk("uf_prog", prog, 32'h3000);

    // Push+pop with one entry: replace
    step(1, 1, 0, 32'h78, 32'h3004);
    chk("pp_count", 32'(count), 32'd1);
    chk("pp_prog",  prog, 32'h3004);
    step(0, 1, 0, '0, '0);
    // Push+pop on empty: only the push happens
    step(1, 1, 0, 32'h79, 32'h3008);
    chk("pe_count", 32'(count), 32'd1);
    chk("pe_inst",  inst, 32'h79);
    chk("pe_prog",  prog, 32'h3008);

    // Grow to 7 entries, then asynchronous reset mid-cycle
    for (int k = 0; k < 6; k++)
      step(1, 0, 0, 32'h100 + 32'(k), 32'h4000 + 32'(4 * k));
    chk("pre_rst_count", 32'(count), 32'd7);
    #2 rst = 1'b0;
    #1;
    chk("arst_empty", 32'(is_iqueue_empty), 32'd1);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_inst",  inst, 32'h0);
`ifdef IQUEUE_PERF_EN
    chk("arst_flcnt", flush_count, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    step(1, 0, 0, 32'h00A00513, 32'h5000);
    chk("post_inst",  inst, 32'h00A00513);
    chk("post_prog",  prog, 32'h5000);
    chk("post_count", 32'(count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_queue.md
Name: instruction_queue

Overview:
- Circular FIFO between fetch and rename/dispatch. Buffers fetched instruction words together with their PCs.
- Presents the head entry show-ahead to rename/dispatch, which pops it with dequeue.
- Back-pressures fetch via full.
- Flushed whole on a branch redirect, so wrong-path instructions never reach rename.

Parameters:
- DEPTH, 16, number of entries; must be a power of two and at least 2.
- PTR_BITS, $clog2(DEPTH), index width; the pointers carry one extra wrap bit.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- enqueue  input  1  fetch has a valid instruction this cycle.
- inst_in  input  32  fetched instruction word.
- pc_in  input  32  PC of inst_in.
- dequeue  input  1  rename/dispatch consumes the head entry this cycle.
- flush  input  1  branch redirect (global_branch_signal); discards all entries.
- inst  output  32  head instruction word.
- prog  output  32  head PC.
- is_iqueue_empty  output  1  no valid entries.
- full  output  1  DEPTH valid entries.
- count  output  PTR_BITS+1  current occupancy, 0..DEPTH.

Behaviour:
- State: storage array of DEPTH x 64 bits {pc, inst}; head and tail pointers of PTR_BITS+1 bits each.
- Empty and full: empty when head == tail (all bits). Full when indices are equal and wrap bits differ. count = tail - head, computed modulo 2^(PTR_BITS+1).
- Reset (rst low, asynchronous): head = tail = 0, so is_iqueue_empty=1, full=0, count=0. The storage array is not reset. inst and prog read 0 while empty.
- Read path is show-ahead, with zero-cycle read latency:
  - inst and prog are combinational from storage[head index].
  - When empty, inst and prog are forced to 32'h0. Rename therefore decodes a NOP-free zero word and must qualify it with is_iqueue_empty.
- Write latency: an entry enqueued in cycle N is visible on inst/prog and clears is_iqueue_empty in cycle N+1. There is no same-cycle bypass.
- Enqueue accept: accepted when !full or when dequeue is accepted in the same cycle. If the queue is full with no dequeue, the enqueue is dropped; fetch must hold its word and retry while full=1.
- Dequeue accept: accepted when !is_iqueue_empty. A dequeue while empty is ignored; pointers and count are unchanged, with no error.
- Simultaneous enqueue and dequeue: both take effect and count is unchanged.
  - This holds at full: the head is popped and the new word is written into the freed slot.
  - When empty, only the enqueue takes effect.
- Flush: has highest priority. In the cycle flush=1 sampled:
  - head and tail are set to 0 at the edge.
  - Any enqueue or dequeue in that cycle is discarded.
  - In cycle N+1, is_iqueue_empty=1 and count=0.
- Wrap-around: the index bits wrap modulo DEPTH and the wrap bit toggles on each crossing. Correct operation is required across arbitrarily many wraps.
- Reset mid-operation: asynchronous clear takes effect immediately, regardless of clk. Operation resumes on the first rising edge after rst deasserts.
- Outputs full and is_iqueue_empty are pure functions of the registered pointers, with no combinational path from the inputs.

Optional Feature:
- Macro IQUEUE_PERF_EN.
- When defined:
  - Adds outputs full_stall_cycles (32 bits) and flush_count (32 bits).
  - full_stall_cycles increments each cycle in which enqueue=1 and the enqueue is dropped.
  - flush_count increments each cycle with flush=1.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0 on rst.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then 3 enqueues: inst_in=32'h00000013/00500093/00108133, pc_in=0x60000000/4/8.
  - One cycle after the first enqueue: inst=32'h00000013, prog=0x60000000, count=1.
  - After 3 enqueues: count=3.
  - 3 dequeues then pop them in order; is_iqueue_empty=1 afterwards.
- Fill with DEPTH=16 enqueues: full=1, count=16.
  - A 17th enqueue without dequeue is dropped; count stays 16.
  - With the perf macro, full_stall_cycles=1.
- Hold full with enqueue and dequeue together for 40 cycles: count stays 16, and the PCs pop in strict enqueue order across 2+ pointer wraps.
- Queue at 5 entries, assert flush together with enqueue and dequeue: next cycle count=0, is_iqueue_empty=1, inst=0. The next enqueue appears at the head.
- Dequeue on an empty queue for 3 cycles: count stays 0, with no underflow; a following enqueue is read back correctly.
- Assert rst low mid-cycle with 7 entries: is_iqueue_empty=1 and count=0 before the next clk edge.
